// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths, slot indices, active-low segment glyphs and the
// shadow-register payload used by the 4-digit multiplexed 7-segment scanner.
package seg7_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SLOT_W     = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    // Slot index == anode bit index
    localparam slot_t SLOT_D = 2'd0;
    localparam slot_t SLOT_C = 2'd1;
    localparam slot_t SLOT_B = 2'd2;
    localparam slot_t SLOT_A = 2'd3;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

    // Captured display payload: four BCD digits plus per-digit dp enables
    typedef struct packed {
        logic [DIGIT_W-1:0]    a;
        logic [DIGIT_W-1:0]    b;
        logic [DIGIT_W-1:0]    c;
        logic [DIGIT_W-1:0]    d;
        logic [NUM_DIGITS-1:0] dp;
    } shadow_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment decoder.
//   code    in  4  digit code; 0..9 standard glyphs, 10..15 dash
//   blank   in  1  force all segments off
//   seg_c   out 7  {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = GLYPH_DASH;
        if (blank) begin
            seg_c = GLYPH_BLANK;
        end else begin
            case (code)
                4'd0:    seg_c = GLYPH_0;
                4'd1:    seg_c = GLYPH_1;
                4'd2:    seg_c = GLYPH_2;
                4'd3:    seg_c = GLYPH_3;
                4'd4:    seg_c = GLYPH_4;
                4'd5:    seg_c = GLYPH_5;
                4'd6:    seg_c = GLYPH_6;
                4'd7:    seg_c = GLYPH_7;
                4'd8:    seg_c = GLYPH_8;
                4'd9:    seg_c = GLYPH_9;
                default: seg_c = GLYPH_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed 7-segment scanner with shadowed inputs,
// per-slot anti-ghosting blank window and optional leading-zero blanking.
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous reset, active-low
//   A,B,C,D   in   4  BCD digits, A leftmost (an[3]) .. D rightmost (an[0])
//   load      in   1  capture A..D and dp_in into the shadow registers
//   blank_lz  in   1  leading-zero blanking enable (used live)
//   dp_in     in   4  decimal-point enable per digit, bit i -> an[i]
//   seg       out  7  {g,f,e,d,c,b,a}, active-low, registered
//   dp        out  1  decimal point, active-low, registered
//   an        out  4  anodes, active-low, registered
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIV   = 2000,
    parameter int unsigned BLANK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGIT_W-1:0]    A,
    input  logic [DIGIT_W-1:0]    B,
    input  logic [DIGIT_W-1:0]    C,
    input  logic [DIGIT_W-1:0]    D,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    slot_t                 slot_q, slot_d;
    shadow_t               shadow_q, shadow_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  last_c;
    logic                  in_blank_c;
    logic [DIGIT_W-1:0]    digit_c;
    logic                  lz_c;
    logic                  dp_sel_c;
    logic [SEG_W-1:0]      dec_seg_c;

    assign last_c = (cnt_q == CNT_W'(DIV - 1));

    // Anti-ghosting window at the start of every slot
    if (BLANK == 0) begin : g_no_blank
        assign in_blank_c = 1'b0;
    end else begin : g_blank
        assign in_blank_c = (cnt_q < CNT_W'(BLANK));
    end

    // Select the active slot's digit and its leading-zero blank condition
    always_comb begin
        digit_c = shadow_q.d;
        lz_c    = 1'b0;
        case (slot_q)
            SLOT_D: begin
                digit_c = shadow_q.d;
                lz_c    = 1'b0;
            end
            SLOT_C: begin
                digit_c = shadow_q.c;
                lz_c    = blank_lz && (shadow_q.a == 4'd0) && (shadow_q.b == 4'd0)
                          && (shadow_q.c == 4'd0);
            end
            SLOT_B: begin
                digit_c = shadow_q.b;
                lz_c    = blank_lz && (shadow_q.a == 4'd0) && (shadow_q.b == 4'd0);
            end
            SLOT_A: begin
                digit_c = shadow_q.a;
                lz_c    = blank_lz && (shadow_q.a == 4'd0);
            end
            default: begin
                digit_c = shadow_q.d;
                lz_c    = 1'b0;
            end
        endcase
    end

    assign dp_sel_c = shadow_q.dp[slot_q];

    seg7_decode u_decode (
        .code  (digit_c),
        .blank (lz_c),
        .seg_c (dec_seg_c)
    );

    // Next-state: prescaler, slot, shadow capture and registered outputs
    always_comb begin
        cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
        slot_d   = last_c ? slot_q + 2'd1 : slot_q;
        shadow_d = shadow_q;
        an_d     = 4'b1111;
        seg_d    = GLYPH_BLANK;
        dp_d     = 1'b1;

        if (load) begin
            shadow_d = '{a: A, b: B, c: C, d: D, dp: dp_in};
        end

        if (!in_blank_c) begin
            an_d  = ~(4'b0001 << slot_q);
            seg_d = dec_seg_c;
            dp_d  = ~dp_sel_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            slot_q   <= SLOT_D;
            shadow_q <= '0;
            an_q     <= 4'b1111;
            seg_q    <= GLYPH_BLANK;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed bench for seg7_scan with DIV=16, BLANK=2.
// Tracks the scan phase from reset release and checks every output each cycle.
module tb_seg7_scan;

    logic       clk;
    logic       rst;
    logic [3:0] A, B, C, D;
    logic       load;
    logic       blank_lz;
    logic [3:0] dp_in;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected shadow contents
    logic [3:0] m_a, m_b, m_c, m_d, m_dp;

    seg7_scan #(.DIV(16), .BLANK(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .load     (load),
        .blank_lz (blank_lz),
        .dp_in    (dp_in),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // One clock; then compare outputs against the state held before that edge
    task automatic tick_check();
        int g, slot, cnt;
        logic [3:0] e_an, dig;
        logic [6:0] e_seg;
        logic       e_dp, lz;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        g    = cyc - 1;
        slot = (g / 16) % 4;
        cnt  = g % 16;
        if (cnt < 2) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
        end else begin
            case (slot)
                0: begin dig = m_d; lz = 1'b0; e_an = 4'b1110; end
                1: begin dig = m_c; lz = blank_lz && m_a == 0 && m_b == 0 && m_c == 0; e_an = 4'b1101; end
                2: begin dig = m_b; lz = blank_lz && m_a == 0 && m_b == 0; e_an = 4'b1011; end
                default: begin dig = m_a; lz = blank_lz && m_a == 0; e_an = 4'b0111; end
            endcase
            e_seg = lz ? 7'b1111111 : glyph(dig);
            e_dp  = ~m_dp[slot];
        end
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_check();
    endtask

    // Load pulse on the next edge; shadow model updates after that edge's outputs
    task automatic do_load(input logic [3:0] a, b, c, d, dpv);
        A = a; B = b; C = c; D = d; dp_in = dpv;
        load = 1'b1;
        tick_check();
        load = 1'b0;
        m_a = a; m_b = b; m_c = c; m_d = d; m_dp = dpv;
    endtask

    task automatic run_to_phase(input int ph);
        int guard;
        guard = 0;
        while ((cyc % 64) != ph && guard < 128) begin
            tick_check();
            guard++;
        end
        check("phase_reached", 32'(cyc % 64), 32'(ph));
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; blank_lz = 1'b0;
        A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0; dp_in = 4'd0;
        m_a = 4'd0; m_b = 4'd0; m_c = 4'd0; m_d = 4'd0; m_dp = 4'd0;

        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'h0000000f);
        check("rst_seg", 32'(seg), 32'h0000007f);
        check("rst_dp", 32'(dp), 32'h00000001);
        rst = 1'b1;
        cyc = 0;

        // Digits 1,2,3,4: scan order D,C,B,A with 2-cycle gaps
        do_load(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
        run(64);

        // Leading-zero blanking on, then off
        do_load(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
        blank_lz = 1'b1;
        run(64);
        blank_lz = 1'b0;
        run(64);

        // A blanked, B dash, C zero kept, D=5
        blank_lz = 1'b1;
        do_load(4'd0, 4'd12, 4'd0, 4'd5, 4'b0000);
        run(64);
        blank_lz = 1'b0;

        // Decimal point on an[2] only
        do_load(4'd5, 4'd6, 4'd8, 4'd9, 4'b0100);
        run(64);

        // Load on the slot 2 -> 3 advance edge
        run_to_phase(47);
        do_load(4'd9, 4'd6, 4'd8, 4'd9, 4'b0000);
        run(20);

        // Async reset at cnt=9 of slot 1
        run_to_phase(26);
        check("pre_rst_an", 32'(an), 32'h0000000d);
        #2 rst = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h0000000f);
        check("async_rst_seg", 32'(seg), 32'h0000007f);
        check("async_rst_dp", 32'(dp), 32'h00000001);
        @(posedge clk);
        @(negedge clk);
        check("held_rst_an", 32'(an), 32'h0000000f);
        rst = 1'b1;
        cyc = 0;
        m_a = 4'd0; m_b = 4'd0; m_c = 4'd0; m_d = 4'd0; m_dp = 4'd0;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 2000: clk cycles per digit slot; legal range 4..65535.
REQ-002 Parameter BLANK, default 8: leading cycles of each slot with all anodes off (anti-ghosting); legal 0..DIV-2.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 A  in  4  BCD thousands digit (leftmost, an[3]).
REQ-006 B  in  4  BCD hundreds digit (an[2]).
REQ-007 C  in  4  BCD tens digit (an[1]).
REQ-008 D  in  4  BCD units digit (an[0]).
REQ-009 load  in  1  capture A..D and dp_in into shadow registers.
REQ-010 blank_lz  in  1  enable leading-zero blanking.
REQ-011 dp_in  in  4  decimal-point enable per digit, bit i -> an[i], active-high.
REQ-012 seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 dp  out  1  decimal point, active-low, registered.
REQ-014 an  out  4  digit anodes, active-low, one-hot-low or all-high, registered.

Function
REQ-015 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; slot index SHALL advance on the cycle cnt==DIV-1.
REQ-016 Slot order SHALL be 0 (D, an[0]) -> 1 (C) -> 2 (B) -> 3 (A) -> 0, wrapping without gap.
REQ-017 While cnt<BLANK, next an SHALL be 4'b1111, seg 7'b1111111, dp 1.
REQ-018 While cnt>=BLANK, next an SHALL drive only bit[slot] low; seg/dp SHALL show the shadow digit and shadow dp of that slot.
REQ-019 All outputs SHALL be registered: values reflect cnt/slot/shadow of the previous cycle (1-cycle latency).
REQ-020 On a rising edge with load=1, shadow A..D and dp SHALL take the inputs; the new value appears on outputs at the following edge (2 edges after load sampled) if that slot is active.
REQ-021 load with no slot change and load coinciding with slot advance SHALL both apply; the display never mixes old and new values within one cycle.
REQ-022 Digit codes 0..9 SHALL decode to standard glyphs (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000).
REQ-023 Codes 10..15 SHALL decode to dash, segment g only (7'b0111111).
REQ-024 With blank_lz=1: A blanked if A==0; B if A==0 and B==0; C if A==B==C==0; D never blanked.
REQ-025 A blanked digit SHALL drive seg 7'b1111111 with its anode still active; dp follows dp_in regardless of blanking.
REQ-026 blank_lz SHALL be sampled live (not shadowed); a change affects the next cycle's outputs.

Reset
REQ-027 rst=0 SHALL immediately force cnt=0, slot=0, shadow digits=0, shadow dp=0, an=4'b1111, seg=7'b1111111, dp=1.
REQ-028 After rst release, first slot (D) SHALL begin at cnt=0 on the first edge; reset mid-slot abandons the slot without glitching anodes low.

Structure
REQ-029 Package seg7_pkg SHALL hold the segment glyph constants (0..9, DASH, BLANK) and slot index constants.
REQ-030 One combinational sub-module seg7_decode (4-bit code + blank flag -> 7-bit active-low segments) SHALL be used once, on the muxed slot digit.
REQ-031 cnt width SHALL be $clog2(DIV); no latches, no derived clocks.

Verification (DIV=16, BLANK=2)
REQ-032 load A..D=1,2,3,4, dp_in=0 -> an cycles 1110,1101,1011,0111 each 14 cycles, with 2-cycle 1111 gaps; seg = glyph 4,3,2,1 respectively.
REQ-033 load 0,0,0,7, blank_lz=1 -> an[3..1] slots seg=1111111, an[0] slot glyph 7; blank_lz=0 -> glyph 0 on an[3..1].
REQ-034 load 0,12,0,5, blank_lz=1 -> A blanked, B dash 0111111, C glyph 0 (not blanked), D glyph 5.
REQ-035 load pulse on the cnt==15 edge while slot 2 -> slot 3 shows new A on its first non-blank cycle; no cycle shows the old value after the update.
REQ-036 Assert rst=0 at cnt=9 of slot 1 -> same-cycle an=1111, seg=1111111, dp=1; after release, slot 0 shows 0 from cnt>=2.
REQ-037 dp_in=4'b0100 with load -> dp=0 only during an=1011 non-blank cycles.
